// File: rtl/fetch_queue_unit_pkg.sv
// Shared widths, reset PC and payload types for the queued fetch front end.
package fetch_queue_unit_pkg;

    localparam int unsigned FETCH_TO_DEC_BUS_WD = 64;
    localparam int unsigned BR_BUS_WD           = 33;
    localparam int unsigned IBUF_ENTRY_WD       = 65;
    localparam logic [31:0] RESET_PC_DEFAULT    = 32'h1c000000;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } br_bus_t;

    typedef struct packed {
        logic        adef;
        logic [31:0] inst;
        logic [31:0] pc;
    } ibuf_entry_t;

    // Bits needed to hold a count in 0..n
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fetch_queue_unit_sync_fifo.sv
// Small synchronous FIFO with flush; head is a combinational read of the oldest slot.
module fetch_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_c,
    output logic [CW-1:0]    count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             empty_c;
    logic             full_c;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    assign empty_c = (count == '0);
    assign full_c  = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty_c;
    // A push into a full FIFO is legal only when the head leaves in the same cycle
    assign do_push = push & (~full_c | do_pop);
    assign head_c  = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_queue_unit.sv
// Pre-IF/IF front end: multiple outstanding SRAM fetches feeding an instruction buffer,
// with count-based discard of stale responses after a redirect.
module fetch_queue_unit
    import fetch_queue_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned IBUF_DEPTH      = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [BR_BUS_WD-1:0]           branch_bus,
    input  logic                           csr_is_branch,
    input  logic [31:0]                    csr_pc_if,
    input  logic                           dec_allowin,
    output logic                           fetch_to_dec_valid,
    output logic [FETCH_TO_DEC_BUS_WD-1:0] fetch_to_decode_bus,
    output logic                           ADEF_to_ID,
    output logic                           inst_sram_req,
    output logic                           inst_sram_wr,
    output logic [1:0]                     inst_sram_size,
    output logic [3:0]                     inst_sram_wstrb,
    output logic [31:0]                    inst_sram_addr,
    output logic [31:0]                    inst_sram_wdata,
    input  logic                           inst_sram_addr_ok,
    input  logic                           inst_sram_data_ok,
    input  logic [31:0]                    inst_sram_rdata
);

    localparam int unsigned OW = cnt_width(MAX_OUTSTANDING);
    localparam int unsigned BW = cnt_width(IBUF_DEPTH);

    br_bus_t     br;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] fetch_pc;
    logic        adef_halt;
    logic        misaligned;
    logic        credit_ok;
    logic        hs;
    logic [OW-1:0] inflight;
    logic [OW-1:0] inflight_nxt;
    logic [OW-1:0] cancel_cnt;
    logic [31:0] pc_head;
    logic [BW-1:0] ibuf_count;
    logic        ibuf_full;
    logic        ibuf_empty;
    logic        data_push;
    logic        adef_push;
    logic        ibuf_push;
    logic        ibuf_pop;
    ibuf_entry_t ibuf_in;
    ibuf_entry_t ibuf_head;

    assign br       = br_bus_t'(branch_bus);
    assign redirect = csr_is_branch | br.taken;
    assign target   = csr_is_branch ? csr_pc_if : br.target;

    assign misaligned = (fetch_pc[1:0] != 2'b00);
    // Credits count stale traffic too, so every returning response has a slot
    assign credit_ok  = (inflight < OW'(MAX_OUTSTANDING)) &&
                        ((32'(inflight) + 32'(ibuf_count)) < IBUF_DEPTH);

    assign inst_sram_req   = ~reset & ~redirect & ~adef_halt & ~misaligned & credit_ok;
    assign inst_sram_addr  = fetch_pc;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'b0000;
    assign inst_sram_wdata = 32'h0;

    assign hs           = inst_sram_req & inst_sram_addr_ok;
    assign inflight_nxt = OW'(32'(inflight) + 32'(hs) - 32'(inst_sram_data_ok));

    assign ibuf_full  = (ibuf_count == BW'(IBUF_DEPTH));
    assign ibuf_empty = (ibuf_count == '0);
    assign data_push  = inst_sram_data_ok & (cancel_cnt == '0) & ~redirect;
    // Fault entry only once the bus holds nothing but stale traffic
    assign adef_push  = misaligned & ~adef_halt & ~redirect & ~ibuf_full & (inflight == cancel_cnt);
    assign ibuf_push  = data_push | adef_push;

    always_comb begin
        ibuf_in = '{adef: 1'b1, inst: 32'h0, pc: fetch_pc};
        if (data_push) ibuf_in = '{adef: 1'b0, inst: inst_sram_rdata, pc: pc_head};
    end

    assign fetch_to_dec_valid  = ~ibuf_empty & ~redirect;
    assign ibuf_pop            = fetch_to_dec_valid & dec_allowin;
    assign fetch_to_decode_bus = {ibuf_head.inst, ibuf_head.pc};
    assign ADEF_to_ID          = fetch_to_dec_valid & ibuf_head.adef;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc   <= RESET_PC;
            cancel_cnt <= '0;
            adef_halt  <= 1'b0;
        end else if (redirect) begin
            fetch_pc   <= target;
            cancel_cnt <= inflight_nxt;
            adef_halt  <= 1'b0;
        end else begin
            if (hs) fetch_pc <= fetch_pc + 32'd4;
            if (inst_sram_data_ok && (cancel_cnt != '0)) cancel_cnt <= cancel_cnt - OW'(1);
            if (adef_push) adef_halt <= 1'b1;
        end
    end

    // PC tracker occupancy doubles as the in-flight request count
    fetch_sync_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pc_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (hs),
        .push_data (fetch_pc),
        .pop       (inst_sram_data_ok),
        .flush     (1'b0),
        .head_c    (pc_head),
        .count     (inflight)
    );

    fetch_sync_fifo #(
        .WIDTH (IBUF_ENTRY_WD),
        .DEPTH (IBUF_DEPTH)
    ) u_ibuf (
        .clk       (clk),
        .reset     (reset),
        .push      (ibuf_push),
        .push_data (ibuf_in),
        .pop       (ibuf_pop),
        .flush     (redirect),
        .head_c    (ibuf_head),
        .count     (ibuf_count)
    );

    a_no_orphan_data_ok: assert property (@(posedge clk) disable iff (reset)
        !(inst_sram_data_ok && (inflight == '0)));

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Randomised bench for fetch_queue_unit: SRAM slave model plus decode-stream reference model.
module tb_fetch_queue_unit;

    localparam logic [31:0] RST_PC = 32'h1c000000;
    localparam int unsigned MAXO   = 2;
    localparam int unsigned DEPTH  = 4;

    logic        clk;
    logic        reset;
    logic [32:0] branch_bus;
    logic        csr_is_branch;
    logic [31:0] csr_pc_if;
    logic        dec_allowin;
    logic        fetch_to_dec_valid;
    logic [63:0] fetch_to_decode_bus;
    logic        ADEF_to_ID;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    int n_checks = 0;
    int n_errors = 0;

    int unsigned cyc = 0;
    int unsigned ok_rand = 0;
    int unsigned dmin = 0;
    int unsigned dmax = 0;
    logic [31:0] addr_q[$];
    int unsigned due_q[$];
    int hs_total = 0;
    int pop_total = 0;

    logic [31:0] exp_pc = RST_PC;
    logic        exp_halt = 1'b0;
    logic        prev_pend = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    fetch_queue_unit #(
        .RESET_PC        (RST_PC),
        .MAX_OUTSTANDING (MAXO),
        .IBUF_DEPTH      (DEPTH)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .branch_bus          (branch_bus),
        .csr_is_branch       (csr_is_branch),
        .csr_pc_if           (csr_pc_if),
        .dec_allowin         (dec_allowin),
        .fetch_to_dec_valid  (fetch_to_dec_valid),
        .fetch_to_decode_bus (fetch_to_decode_bus),
        .ADEF_to_ID          (ADEF_to_ID),
        .inst_sram_req       (inst_sram_req),
        .inst_sram_wr        (inst_sram_wr),
        .inst_sram_size      (inst_sram_size),
        .inst_sram_wstrb     (inst_sram_wstrb),
        .inst_sram_addr      (inst_sram_addr),
        .inst_sram_wdata     (inst_sram_wdata),
        .inst_sram_addr_ok   (inst_sram_addr_ok),
        .inst_sram_data_ok   (inst_sram_data_ok),
        .inst_sram_rdata     (inst_sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0], ~pc[31:16]} ^ 32'h13579bdf;
    endfunction

    // SRAM slave: in-order responses, each at least one cycle after its address handshake
    always @(negedge clk) begin
        inst_sram_addr_ok = (ok_rand == 0) ? 1'b1 : ($urandom_range(0, ok_rand) == 0);
        inst_sram_data_ok = (due_q.size() != 0) && (due_q[0] <= cyc);
        inst_sram_rdata   = inst_sram_data_ok ? inst_of(addr_q[0]) : $urandom();
    end

    // Monitor: decode stream must be target, target+4, ... after each redirect
    always begin
        logic        redir;
        logic [31:0] tgt;
        @(negedge clk);
        #4;
        if (reset) begin
            addr_q.delete();
            due_q.delete();
            exp_pc    = RST_PC;
            exp_halt  = 1'b0;
            prev_pend = 1'b0;
        end else begin
            redir = csr_is_branch | branch_bus[32];
            tgt   = csr_is_branch ? csr_pc_if : branch_bus[31:0];
            if (fetch_to_dec_valid) begin
                if (redir) begin
                    check("valid_in_redirect", 64'(fetch_to_dec_valid), 64'd0);
                end else if (exp_halt) begin
                    check("valid_after_adef", 64'(fetch_to_dec_valid), 64'd0);
                end else if (dec_allowin) begin
                    check("dec_pc", 64'(fetch_to_decode_bus[31:0]), 64'(exp_pc));
                    check("dec_adef", 64'(ADEF_to_ID), 64'(exp_pc[1:0] != 2'b00));
                    if (exp_pc[1:0] != 2'b00) begin
                        check("dec_adef_inst", 64'(fetch_to_decode_bus[63:32]), 64'd0);
                        exp_halt = 1'b1;
                    end else begin
                        check("dec_inst", 64'(fetch_to_decode_bus[63:32]), 64'(inst_of(exp_pc)));
                        exp_pc = exp_pc + 32'd4;
                    end
                    pop_total++;
                end
            end
            if (inst_sram_req) check("req_aligned", 64'(inst_sram_addr[1:0]), 64'd0);
            if (prev_pend && !redir)
                check("req_hold", 64'({inst_sram_req, inst_sram_addr}), 64'({1'b1, prev_addr}));
            if (inst_sram_req && inst_sram_addr_ok) begin
                addr_q.push_back(inst_sram_addr);
                due_q.push_back(cyc + 1 + $urandom_range(dmin, dmax));
                hs_total++;
                check("inflight_max", 64'(addr_q.size() > MAXO), 64'd0);
            end
            if (inst_sram_data_ok) begin
                void'(addr_q.pop_front());
                void'(due_q.pop_front());
            end
            if (redir) begin
                exp_pc   = tgt;
                exp_halt = 1'b0;
            end
            prev_pend = inst_sram_req & ~inst_sram_addr_ok & ~redir;
            prev_addr = inst_sram_addr;
        end
        cyc++;
    end

    task automatic clear_redirect();
        branch_bus    = {1'b0, $urandom()};
        csr_is_branch = 1'b0;
        csr_pc_if     = $urandom();
    endtask

    // Drive a one-cycle redirect mid-cycle, then release it at the next falling edge
    task automatic redirect_pulse(input logic csr, input logic [31:0] csr_pc,
                                  input logic br, input logic [31:0] br_pc);
        branch_bus    = {br, br_pc};
        csr_is_branch = csr;
        csr_pc_if     = csr_pc;
        #1;
        check("redir_req_low", 64'(inst_sram_req), 64'd0);
        check("redir_valid_low", 64'(fetch_to_dec_valid), 64'd0);
        @(negedge clk);
        clear_redirect();
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] pc, input logic adef);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (i > 0) @(negedge clk);
            #3;
            if (fetch_to_dec_valid) found = 1'b1;
        end
        check({tag, "_found"}, 64'(found), 64'd1);
        check({tag, "_pc"}, 64'(fetch_to_decode_bus[31:0]), 64'(pc));
        check({tag, "_adef"}, 64'(ADEF_to_ID), 64'(adef));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        logic found;
        reset       = 1'b1;
        dec_allowin = 1'b1;
        clear_redirect();
        repeat (3) @(negedge clk);
        #3;
        check("rst_req", 64'(inst_sram_req), 64'd0);
        check("rst_valid", 64'(fetch_to_dec_valid), 64'd0);
        check("rst_adef", 64'(ADEF_to_ID), 64'd0);
        check("rst_addr", 64'(inst_sram_addr), 64'(RST_PC));

        // Back-to-back fetch with a zero-wait bus
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            #3;
            if (k == 0) begin
                check("first_req", 64'(inst_sram_req), 64'd1);
                check("first_addr", 64'(inst_sram_addr), 64'(RST_PC));
            end
            if (k >= 2) begin
                check("t1_valid", 64'(fetch_to_dec_valid), 64'd1);
                check("t1_pc", 64'(fetch_to_decode_bus[31:0]), 64'(RST_PC + 32'(4 * (k - 2))));
            end
        end

        // Decode stall fills the buffer and stops requests
        @(negedge clk);
        dec_allowin = 1'b0;
        repeat (9) @(negedge clk);
        #3;
        check("stall_buffered", 64'(hs_total - pop_total), 64'(DEPTH));
        check("stall_req_low", 64'(inst_sram_req), 64'd0);
        check("stall_no_inflight", 64'(addr_q.size()), 64'd0);
        check("stall_valid", 64'(fetch_to_dec_valid), 64'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            dec_allowin = 1'b1;
            #3;
            check("drain_valid", 64'(fetch_to_dec_valid), 64'd1);
        end

        // Branch with two requests outstanding
        dmin = 3;
        dmax = 3;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            #3;
            if (addr_q.size() == 2) found = 1'b1;
        end
        check("t3_two_inflight", 64'(found), 64'd1);
        redirect_pulse(1'b0, 32'h0, 1'b1, 32'h1c000100);
        wait_valid("t3_branch", 32'h1c000100, 1'b0);

        // CSR redirect wins over a simultaneous branch
        dmin = 0;
        dmax = 2;
        repeat (5) @(negedge clk);
        #3;
        redirect_pulse(1'b1, 32'h1c008000, 1'b1, 32'h1c000200);
        wait_valid("t4_csr", 32'h1c008000, 1'b0);

        // Misaligned target produces a single fault entry and halts
        repeat (4) @(negedge clk);
        #3;
        redirect_pulse(1'b0, 32'h0, 1'b1, 32'h1c000102);
        wait_valid("t5_adef", 32'h1c000102, 1'b1);
        repeat (10) @(negedge clk);
        #3;
        check("adef_halt_req", 64'(inst_sram_req), 64'd0);
        check("adef_halt_valid", 64'(fetch_to_dec_valid), 64'd0);
        redirect_pulse(1'b0, 32'h0, 1'b1, 32'h1c000400);
        wait_valid("t5_resume", 32'h1c000400, 1'b0);

        // Random bus timing, decode stalls and redirects
        ok_rand = 3;
        dmin    = 0;
        dmax    = 5;
        begin
            int pops_start;
            pops_start = pop_total;
            for (int i = 0; i < 3000; i++) begin
                @(negedge clk);
                dec_allowin = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 15) == 0) begin
                    logic        c;
                    logic        b;
                    logic [31:0] t;
                    c = 1'($urandom_range(0, 1));
                    b = c ? 1'($urandom_range(0, 1)) : 1'b1;
                    t = 32'h1c000000 + (32'($urandom_range(0, 255)) << 2);
                    if ($urandom_range(0, 7) == 0) t = t + 32'd2;
                    csr_is_branch = c;
                    csr_pc_if     = c ? t : $urandom();
                    branch_bus    = {b, (c ? $urandom() : t)};
                end else begin
                    clear_redirect();
                end
            end
            @(negedge clk);
            clear_redirect();
            check("rand_progress", 64'(pop_total - pops_start > 300), 64'd1);
        end

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
